// File: rtl/irrigation_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// irrigation_scheduler_pkg : shared state encodings, outlet indices, BCD helper
// Revision: 1.0
// ============================================================================
package irrigation_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_IRRIGATE = 2'b01,
      ST_REFILL   = 2'b10,
      ST_COOLDOWN = 2'b11
   } state_t;

   localparam int OUT_SPRINKLER = 0;
   localparam int OUT_DRIP      = 1;
   localparam int OUT_SPECIFIC  = 2;

   // Seconds (0..39) to the {dozens[1:0], units[3:0]} BCD pair.
   function automatic logic [5:0] sec_to_bcd(input int sec);
      return {2'(sec / 10), 4'(sec % 10)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/irrigation_scheduler_bcd_down_counter_30.sv
`default_nettype none
// ============================================================================
// bcd_down_counter_30 : two-digit BCD down counter that saturates at 00
// Revision: 1.0
// ============================================================================
module bcd_down_counter_30 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [5:0] load_value_i,
   input  logic       enable_i,
   input  logic       hold_i,
   output logic [1:0] dozens_o,
   output logic [3:0] units_o,
   output logic       is_zero_o
);

   logic [1:0] dozens_q;
   logic [3:0] units_q;

   assign is_zero_o = (dozens_q == 2'd0) && (units_q == 4'd0);

   // Load takes precedence over a decrement requested in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dozens_q <= 2'd0;
         units_q  <= 4'd0;
      end else if (load_i) begin
         dozens_q <= load_value_i[5:4];
         units_q  <= load_value_i[3:0];
      end else if (enable_i && !hold_i && !is_zero_o) begin
         if (units_q == 4'd0) begin
            units_q  <= 4'd9;
            dozens_q <= dozens_q - 2'd1;
         end else begin
            units_q  <= units_q - 4'd1;
         end
      end
   end

   assign dozens_o = dozens_q;
   assign units_o  = units_q;

endmodule
`default_nettype wire

// File: rtl/irrigation_scheduler.sv
`default_nettype none
// ============================================================================
// irrigation_scheduler : arbitrates the shared water box between three outlets
// Revision: 1.0
// ============================================================================
module irrigation_scheduler
   import irrigation_scheduler_pkg::*;
#(
   parameter int SPRINKLER_SEC = 30,
   parameter int DRIP_SEC      = 20,
   parameter int SPECIFIC_SEC  = 10,
   parameter int COOLDOWN_SEC  = 5
) (
   input  logic       clock_50MHz,
   input  logic       reset_n,
   input  logic       tick_1hz,
   input  logic [2:0] req,
   input  logic [1:0] water_box,
   input  logic       button,
   output logic [2:0] valves,
   output logic       pump,
   output logic [1:0] state,
   output logic [1:0] dozens,
   output logic [3:0] units,
   output logic       time_over
);

   localparam logic [5:0] SPRINKLER_BCD = sec_to_bcd(SPRINKLER_SEC);
   localparam logic [5:0] DRIP_BCD      = sec_to_bcd(DRIP_SEC);
   localparam logic [5:0] SPECIFIC_BCD  = sec_to_bcd(SPECIFIC_SEC);
   localparam logic [5:0] COOLDOWN_BCD  = sec_to_bcd(COOLDOWN_SEC);

   state_t     state_q, state_d;
   logic [2:0] grant_q, grant_d;
   logic [2:0] valves_q;
   logic       pump_q;
   logic       time_over_q, time_over_d;

   logic [2:0] pick;
   logic [5:0] pick_bcd;
   logic       cnt_load;
   logic [5:0] cnt_load_value;
   logic       cnt_run;
   logic       cnt_zero;
   logic       timeout;

   // Fixed priority: specific > drip > sprinkler.
   always_comb begin
      pick     = 3'b000;
      pick_bcd = 6'd0;
      if (req[OUT_SPECIFIC]) begin
         pick[OUT_SPECIFIC] = 1'b1;
         pick_bcd           = SPECIFIC_BCD;
      end else if (req[OUT_DRIP]) begin
         pick[OUT_DRIP] = 1'b1;
         pick_bcd       = DRIP_BCD;
      end else if (req[OUT_SPRINKLER]) begin
         pick[OUT_SPRINKLER] = 1'b1;
         pick_bcd            = SPRINKLER_BCD;
      end
   end

   assign timeout = tick_1hz && cnt_zero;

   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      time_over_d    = 1'b0;
      cnt_load       = 1'b0;
      cnt_load_value = COOLDOWN_BCD;
      cnt_run        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req != 3'b000) begin
               grant_d        = pick;
               cnt_load       = 1'b1;
               cnt_load_value = pick_bcd;
               state_d        = (water_box != 2'b00) ? ST_IRRIGATE : ST_REFILL;
            end
         end
         ST_IRRIGATE: begin
            // Timeout outranks both abort and a dry box in the same cycle.
            if (timeout) begin
               time_over_d = 1'b1;
               grant_d     = 3'b000;
               cnt_load    = 1'b1;
               state_d     = ST_COOLDOWN;
            end else if (button) begin
               grant_d  = 3'b000;
               cnt_load = 1'b1;
               state_d  = ST_COOLDOWN;
            end else if (water_box == 2'b00) begin
               state_d = ST_REFILL;
            end else begin
               cnt_run = 1'b1;
            end
         end
         ST_REFILL: begin
            if (button) begin
               grant_d  = 3'b000;
               cnt_load = 1'b1;
               state_d  = ST_COOLDOWN;
            end else if (water_box == 2'b11) begin
               state_d = (grant_q != 3'b000) ? ST_IRRIGATE : ST_IDLE;
            end
         end
         ST_COOLDOWN: begin
            if (timeout) state_d = ST_IDLE;
            else         cnt_run = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         grant_q     <= 3'b000;
         valves_q    <= 3'b000;
         pump_q      <= 1'b0;
         time_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         valves_q    <= (state_d == ST_IRRIGATE) ? grant_d : 3'b000;
         pump_q      <= (state_d == ST_REFILL);
         time_over_q <= time_over_d;
      end
   end

   bcd_down_counter_30 u_timer (
      .clk          (clock_50MHz),
      .rst_n        (reset_n),
      .load_i       (cnt_load),
      .load_value_i (cnt_load_value),
      .enable_i     (tick_1hz),
      .hold_i       (!cnt_run),
      .dozens_o     (dozens),
      .units_o      (units),
      .is_zero_o    (cnt_zero)
   );

   assign valves    = valves_q;
   assign pump      = pump_q;
   assign state     = state_q;
   assign time_over = time_over_q;

endmodule
`default_nettype wire
